instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and issues word reads to instruction memory over a request/response handshake.
- Presents each fetched instruction and its PC in an IF/ID output register; o_instr[6:0] drives the decoder opcode input.
- Supports downstream stall and redirect (branch/jump target from execute), including discard of stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, value of o_instr on reset and after flush (addi x0,x0,0)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, asynchronous, active-high
o_imem_req  output  1  read request valid
o_imem_addr  output  32  word-aligned read address (= pc)
i_imem_ready  input  1  memory accepts request this cycle
i_imem_rvalid  input  1  read data valid; at most one response per accepted request, >=1 cycle after acceptance
i_imem_rdata  input  32  read data
o_valid  output  1  IF/ID register holds a live instruction
o_instr  output  32  IF/ID instruction
o_pc  output  32  PC of o_instr
i_stall  input  1  decode cannot consume this cycle; consumed when o_valid && !i_stall
i_redirect  input  1  flush and restart fetch at i_redirect_pc
i_redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (async assert, sync use of deassert): pc=RESET_PC, state=REQ, o_valid=0, o_instr=NOP_INSTR, o_pc=RESET_PC, skid empty. o_imem_req=1 in the first cycle after deassert.
- o_imem_req = (state==REQ); o_imem_addr = pc. Only one request is outstanding at a time.
- REQ: if i_imem_ready -> WAIT. i_imem_rvalid is ignored in REQ.
- WAIT, on i_imem_rvalid:
  - If the slot is free (!o_valid || !i_stall): load o_instr=rdata, o_pc=pc, o_valid=1, pc=pc+4 (mod 2^32) -> REQ.
  - Otherwise: latch {rdata, pc} into the skid register, pc=pc+4 -> HOLD.
- HOLD: when !i_stall, move skid into the IF/ID register (o_valid=1) -> REQ.
- DRAIN: discard the next i_imem_rvalid -> REQ. No IF/ID update.
- Consume without a new load: o_valid<=0. o_instr and o_pc hold their values.
- Stall: while o_valid && i_stall, o_valid, o_instr and o_pc are unchanged.
- Redirect has priority over every other event in the same cycle:
  - pc<=i_redirect_pc&~3; o_valid<=0; o_instr<=NOP_INSTR; skid cleared.
  - Next state:
    - REQ with !i_imem_ready -> REQ. Address changes next cycle; this is the only permitted address change while req is pending.
    - REQ with i_imem_ready -> DRAIN (old-address request was accepted).
    - WAIT without rvalid -> DRAIN.
    - WAIT with rvalid -> REQ (data dropped).
    - HOLD -> REQ.
    - DRAIN without rvalid -> DRAIN.
    - DRAIN with rvalid -> REQ.
- Throughput: 1 instruction per 2 cycles with zero-wait memory (REQ->WAIT->REQ).
- Latency: rvalid at cycle t -> o_valid at t+1.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Reset mid-operation clears every state, including DRAIN. The memory is reset together with this block, so no stale response arrives after reset.

Test Plan:
- Reset release, RESET_PC=0x100, ready=1, rvalid 1 cycle later with 0x00500093 -> addr 0x100 requested; o_valid=1, o_instr=0x00500093, o_pc=0x100; next req addr 0x104.
- Zero-wait memory, no stall, 4 instrs -> o_valid pulses every 2nd cycle; o_pc sequence 0x100, 0x104, 0x108, 0x10C.
- i_stall held 5 cycles while a second response arrives -> o_instr/o_pc unchanged, state HOLD, no new req. Stall drop -> skid instr appears next cycle, req issued after.
- Redirect to 0x203 in WAIT before rvalid -> o_valid=0, o_instr=NOP_INSTR; the late response is discarded; next req addr 0x200.
- Redirect in the same cycle as rvalid with i_stall=1 -> data dropped, no HOLD, next req addr = target.
- Redirect to 0xFFFFFFFC, fetch 2 instrs -> o_pc 0xFFFFFFFC then 0x00000000. Assert i_rst in WAIT -> immediate o_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction-fetch stage. Owns the PC, issues single-outstanding
//            word reads to instruction memory, and presents fetched
//            instructions in an IF/ID register with stall, skid buffering and
//            redirect (flush + stale-response discard).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // instruction memory request/response
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    // IF/ID register towards decode
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    // REQ  : request pending on the bus (address must stay stable)
    // WAIT : request accepted, waiting for its response
    // HOLD : response captured in the skid register, IF/ID still occupied
    // DRAIN: an accepted request became stale after a redirect; drop its data
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        slot_free;

    // IF/ID can accept a new instruction when empty or being consumed now
    assign slot_free = !valid_q || !i_stall;

    // Next-state and datapath selection; redirect overrides every other event
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (i_redirect) begin
            pc_d         = i_redirect_pc & ~32'd3;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            skid_instr_d = 32'd0;
            skid_pc_d    = 32'd0;
            // Any request already accepted for the old path must be drained
            case (state_q)
                ST_REQ:   state_d = i_imem_ready  ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_d = i_imem_rvalid ? ST_REQ   : ST_DRAIN;
                ST_HOLD:  state_d = ST_REQ;
                ST_DRAIN: state_d = i_imem_rvalid ? ST_REQ   : ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
        end else begin
            // Decode consumed the current instruction; overridden by a load
            if (valid_q && !i_stall) begin
                valid_d = 1'b0;
            end
            case (state_q)
                ST_REQ: begin
                    if (i_imem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        pc_d = pc_q + 32'd4;
                        if (slot_free) begin
                            valid_d = 1'b1;
                            instr_d = i_imem_rdata;
                            opc_d   = pc_q;
                            state_d = ST_REQ;
                        end else begin
                            skid_instr_d = i_imem_rdata;
                            skid_pc_d    = pc_q;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        valid_d = 1'b1;
                        instr_d = skid_instr_q;
                        opc_d   = skid_pc_q;
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (i_imem_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            opc_q        <= RESET_PC;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign o_imem_req  = (state_q == ST_REQ);
    assign o_imem_addr = pc_q;
    assign o_valid     = valid_q;
    assign o_instr     = instr_q;
    assign o_pc        = opc_q;

endmodule
`default_nettype wire
